// File: rtl/alu_share_ctrl.sv
// Arbitrates two requesters onto one shared external 2-bit combinational ALU.
// Handles one operation at a time through IDLE -> ISSUE -> RESP and holds the response until it is consumed.
module alu_share_ctrl #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [1:0] req0_a,
    input  logic [1:0] req0_b,
    input  logic [1:0] req1_a,
    input  logic [1:0] req1_b,
    input  logic [2:0] req0_sel,
    input  logic [2:0] req1_sel,
    output logic [1:0] alu_a,
    output logic [1:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [1:0] alu_result,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [1:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_last_grant;
    logic       r_busy;
    logic       r_rsp_valid;
    logic [1:0] r_a;
    logic [1:0] r_b;
    logic [2:0] r_sel;
    logic       r_id;
    logic       r_rsp_id;
    logic [1:0] r_rsp_result;
    logic       r_rsp_carry;
    logic       r_rsp_err;

    logic       w_idle;
    logic       w_grant;
    logic       w_accept;
    logic [1:0] w_gnt_a;
    logic [1:0] w_gnt_b;
    logic [2:0] w_gnt_sel;

    // Returns the winning requester index; last is the index granted most recently.
    function automatic logic pick_grant(input logic v0, input logic v1, input logic last);
        if (v0 && v1)
            return RR_EN ? ~last : 1'b0;
        else if (v1)
            return 1'b1;
        else
            return 1'b0;
    endfunction

    function automatic logic sel_legal(input logic [2:0] sel);
        return (sel <= 3'd4);
    endfunction

    assign w_idle    = (r_state == S_IDLE);
    assign w_grant   = pick_grant(req0_valid, req1_valid, r_last_grant);
    assign w_gnt_a   = w_grant ? req1_a   : req0_a;
    assign w_gnt_b   = w_grant ? req1_b   : req0_b;
    assign w_gnt_sel = w_grant ? req1_sel : req0_sel;

    // Ready is gated by rst_n so that no requester sees a handshake while reset is held.
    assign req0_ready = rst_n && w_idle && req0_valid && !w_grant;
    assign req1_ready = rst_n && w_idle && req1_valid &&  w_grant;
    assign w_accept   = req0_ready || req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_busy       <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_a          <= 2'b00;
            r_b          <= 2'b00;
            r_sel        <= 3'b000;
            r_id         <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 2'b00;
            r_rsp_carry  <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state      <= S_ISSUE;
                        r_busy       <= 1'b1;
                        r_last_grant <= w_grant;
                        r_a          <= w_gnt_a;
                        r_b          <= w_gnt_b;
                        r_sel        <= w_gnt_sel;
                        r_id         <= w_grant;
                    end
                end
                S_ISSUE: begin
                    // The ALU has had the whole ISSUE cycle to settle on the registered operands.
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_id;
                    if (sel_legal(r_sel)) begin
                        r_rsp_result <= alu_result;
                        r_rsp_carry  <= alu_carry;
                        r_rsp_err    <= 1'b0;
                    end else begin
                        r_rsp_result <= 2'b00;
                        r_rsp_carry  <= 1'b0;
                        r_rsp_err    <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_sel    = r_sel;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_err    = r_rsp_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: a round-robin instance under directed vectors
// plus a fixed-priority instance under permanent contention.
module tb_alu_share_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_sel, req1_sel;
    logic [1:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_sel;
    logic       alu_carry;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err, busy;
    logic [1:0] rsp_result;

    logic       fp_req0_ready, fp_req1_ready;
    logic [1:0] fp_alu_a, fp_alu_b, fp_alu_result;
    logic [2:0] fp_alu_sel;
    logic       fp_alu_carry;
    logic       fp_rsp_valid, fp_rsp_id, fp_rsp_carry, fp_rsp_err, fp_busy;
    logic [1:0] fp_rsp_result;

    typedef struct packed {
        logic       id;
        logic [1:0] res;
        logic       c;
        logic       err;
    } exp_t;

    typedef struct {
        logic       id;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] sel;
        logic [1:0] er;
        logic       ec;
        logic       ee;
    } vec_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   fp_n     = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // External shared ALU: {carry, result}; illegal opcodes produce junk that must be discarded.
    function automatic logic [2:0] alu_model(input logic [1:0] a, input logic [1:0] b, input logic [2:0] sel);
        case (sel)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            default: return 3'b111;
        endcase
    endfunction

    assign {alu_carry, alu_result}       = alu_model(alu_a, alu_b, alu_sel);
    assign {fp_alu_carry, fp_alu_result} = alu_model(fp_alu_a, fp_alu_b, fp_alu_sel);

    alu_share_ctrl #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_sel(req0_sel), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .busy(busy)
    );

    alu_share_ctrl #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(1'b1), .req1_valid(1'b1),
        .req0_ready(fp_req0_ready), .req1_ready(fp_req1_ready),
        .req0_a(2'b10), .req0_b(2'b11), .req1_a(2'b01), .req1_b(2'b01),
        .req0_sel(3'b100), .req1_sel(3'b000),
        .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_sel(fp_alu_sel),
        .alu_result(fp_alu_result), .alu_carry(fp_alu_carry),
        .rsp_valid(fp_rsp_valid), .rsp_ready(1'b1), .rsp_id(fp_rsp_id),
        .rsp_result(fp_rsp_result), .rsp_carry(fp_rsp_carry), .rsp_err(fp_rsp_err),
        .busy(fp_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one request from the current post-edge point and pushes its expected response on accept.
    task automatic issue(input logic id, input logic [1:0] a, input logic [1:0] b, input logic [2:0] sel,
                         input logic [1:0] er, input logic ec, input logic ee, output int waits);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
        end
        waits = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 20) chk("accept_timeout", 0, 1);
        else q.push_back('{id, er, ec, ee});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) chk("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_ready(input string name, output int n);
        n = 0;
        @(negedge clk);
        while (!(req0_ready || req1_ready) && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) chk(name, 0, 1);
    endtask

    // Scoreboard monitor: every response handshake must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_carry", rsp_carry, e.c);
                    chk("rsp_err", rsp_err, e.err);
                end
            end
        end
    end

    // Fixed-priority instance sees both requesters valid forever; req0 must always win.
    initial begin
        forever begin
            @(negedge clk);
            if (fp_rsp_valid) begin
                fp_n++;
                chk("fp_rsp_id", fp_rsp_id, 0);
                chk("fp_rsp_result", {fp_rsp_result, fp_rsp_carry, fp_rsp_err}, {2'b01, 1'b0, 1'b0});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   w;
        int   last;
        logic [4:0] snap;

        vecs[0] = '{1'b1, 2'b11, 2'b01, 3'b001, 2'b10, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 2'b01, 2'b10, 3'b001, 2'b11, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 2'b11, 2'b10, 3'b010, 2'b10, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 2'b01, 2'b10, 3'b011, 2'b11, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 2'b11, 2'b01, 3'b100, 2'b10, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 2'b11, 2'b11, 3'b000, 2'b10, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 2'b11, 2'b11, 3'b101, 2'b00, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 2'b10, 2'b01, 3'b111, 2'b00, 1'b0, 1'b1};

        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 2'b01; req0_b = 2'b10; req0_sel = 3'b000;
        req1_valid = 1'b0; req1_a = 2'b00; req1_b = 2'b00; req1_sel = 3'b000;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {req0_ready, req1_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err, busy}, 0);

        // First accept on the first edge after release, then check issue/response latency.
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(1'b0, 2'b01, 2'b10, 3'b000, 2'b11, 1'b0, 1'b0, w);
        chk("first_accept_wait", w, 0);
        @(negedge clk);
        chk("t1_alu_ops", {alu_a, alu_b, alu_sel}, {2'b01, 2'b10, 3'b000});
        chk("t1_rsp_valid", rsp_valid, 0);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t2_rsp_valid", rsp_valid, 1);
        wait_idle();

        foreach (vecs[i]) begin
            issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].er, vecs[i].ec, vecs[i].ee, w);
            @(negedge clk);
            chk("vec_t1_rsp_valid", rsp_valid, 0);
            @(negedge clk);
            chk("vec_t2_rsp_valid", rsp_valid, 1);
            wait_idle();
        end

        // Back-pressure: response held, a waiting request stays unaccepted.
        rsp_ready = 1'b0;
        issue(1'b0, 2'b01, 2'b01, 3'b000, 2'b10, 1'b0, 1'b0, w);
        req1_valid = 1'b1; req1_a = 2'b10; req1_b = 2'b01; req1_sel = 3'b010;
        @(negedge clk);
        chk("stall_t1_valid", rsp_valid, 0);
        chk("stall_t1_ready", {req0_ready, req1_ready}, 0);
        @(negedge clk);
        chk("stall_t2_valid", rsp_valid, 1);
        snap = {rsp_id, rsp_result, rsp_carry, rsp_err};
        repeat (4) begin
            @(negedge clk);
            chk("stall_hold", {rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err}, {1'b1, snap});
            chk("stall_busy", busy, 1);
            chk("stall_ready", {req0_ready, req1_ready}, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("hs_ready_low", {req0_ready, req1_ready}, 0);
        @(negedge clk);
        chk("post_hs_busy", busy, 0);
        chk("post_hs_req1_ready", req1_ready, 1);
        q.push_back('{1'b1, 2'b00, 1'b0, 1'b0});
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_idle();

        // Round-robin under continuous contention straight out of reset.
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 2'b01; req0_b = 2'b01; req0_sel = 3'b000;
        req1_valid = 1'b1; req1_a = 2'b11; req1_b = 2'b10; req1_sel = 3'b011;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ready("rr_timeout", w);
            if (w >= 20) break;
            chk("rr_grant", req1_ready, i % 2);
            chk("rr_both_ready", req0_ready && req1_ready, 0);
            if (i > 0) chk("rr_gap", cyc - last, 3);
            last = cyc;
            if (req1_ready) q.push_back('{1'b1, 2'b11, 1'b0, 1'b0});
            else            q.push_back('{1'b0, 2'b10, 1'b0, 1'b0});
            @(posedge clk);
        end
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();

        // Reset during ISSUE drops the operation; req0 wins the next contention.
        issue(1'b1, 2'b10, 2'b10, 3'b000, 2'b00, 1'b1, 1'b0, w);
        rst_n = 1'b0;
        #1;
        chk("rst_issue_valid", rsp_valid, 0);
        chk("rst_issue_busy", busy, 0);
        q.delete();
        req0_valid = 1'b1; req0_a = 2'b10; req0_b = 2'b01; req0_sel = 3'b010;
        req1_valid = 1'b1; req1_a = 2'b11; req1_b = 2'b11; req1_sel = 3'b000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_ready("rst_issue_timeout", w);
        chk("rst_issue_regrant", {req0_ready, req1_ready}, 2'b10);
        q.push_back('{1'b0, 2'b00, 1'b0, 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();

        // Reset during RESP clears the held response.
        rsp_ready = 1'b0;
        issue(1'b0, 2'b11, 2'b10, 3'b100, 2'b01, 1'b0, 1'b0, w);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_resp_valid", rsp_valid, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_resp_valid_busy", {rsp_valid, busy}, 0);
        chk("rst_resp_data", {rsp_id, rsp_result, rsp_carry, rsp_err}, 0);
        q.delete();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 2'b01; req0_b = 2'b11; req0_sel = 3'b011;
        req1_valid = 1'b1; req1_a = 2'b11; req1_b = 2'b11; req1_sel = 3'b000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_ready("rst_resp_timeout", w);
        chk("rst_resp_regrant", {req0_ready, req1_ready}, 2'b10);
        q.push_back('{1'b0, 2'b11, 1'b0, 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        chk("fp_responses_seen", fp_n > 5, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
